axi_read_xbar: RTL
==================

Name: axi_read_xbar

Overview:
- 1-to-2 AXI read crossbar directly upstream of the CLINT read slave.
- Accepts read requests from the core's LSU read master, decodes the address, and forwards each request to either the CLINT port or the main-memory port.
- Returns the selected target's R beat to the upstream master.
- Flags CLINT reads so difftest skips device accesses.
- One outstanding transaction at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- CLINT_BASE, 32'h0200_0000, CLINT region base.
- CLINT_MASK, 32'hFFFF_0000, region match mask: hit when (araddr & CLINT_MASK) == CLINT_BASE.

Ports:
- i_clock  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- in  if_axi_read.slave  ADDR_W/DATA_W  upstream read port from the LSU.
- out_clint  if_axi_read.master  ADDR_W/DATA_W  to the CLINT read slave.
- out_mem  if_axi_read.master  ADDR_W/DATA_W  to the memory/SoC read path.
- o_skip_difftest  output  1  one-cycle pulse when a CLINT read beat completes upstream.

Behaviour:
- FSM states: IDLE, ADDR, DATA. Reset state is IDLE. Registers: state, araddr_q, sel_q (0 = mem, 1 = clint), o_skip_difftest.
- Reset (i_reset low, async) forces:
  - state = IDLE, araddr_q = 0, sel_q = 0, o_skip_difftest = 0.
  - Both downstream arvalid = 0; upstream rvalid = 0.
  - This holds even mid-transaction. Any in-flight downstream beat is abandoned; downstream slaves are reset by the same reset.
- in.arready = (state == IDLE). It is combinational from state and is 1 in the first cycle after reset release.
- IDLE:
  - On in.arvalid && in.arready: capture araddr_q = in.araddr and sel_q = decode hit, then go to ADDR.
- ADDR:
  - Selected port sees arvalid = 1 and araddr = araddr_q. The unselected port holds arvalid = 0.
  - Stay in ADDR until the selected arready = 1 in the same cycle, then go to DATA.
  - arvalid/araddr are stable while waiting (AXI rule: no retraction).
- DATA:
  - Pass-through, combinational: in.rvalid, in.rdata and in.rresp come from the selected port; the selected rready = in.rready.
  - Unselected port rready = 0. Its rvalid is ignored.
  - On selected rvalid && in.rready: go to IDLE, and set o_skip_difftest = sel_q for exactly the next cycle.
- Outside DATA: in.rvalid = 0, in.rdata = 0, in.rresp = 0, both downstream rready = 0.
- Latency, zero-wait target:
  - Upstream AR accepted at cycle T.
  - Downstream AR handshake at T+1.
  - Target R at T+2 or later, same cycle upstream.
  - Next upstream AR accepted the cycle after R completes.
  - Minimum 3 cycles per read.
- A new AR cannot be accepted in the same cycle as R completion, because arready is low in DATA.
- Decode boundaries:
  - 0x0200_0000 and 0x0200_FFFF hit CLINT.
  - 0x01FF_FFFC and 0x0201_0000 go to mem.
- rresp is passed unmodified. No decode error is generated: all non-CLINT addresses route to mem.
- Back-pressure: if in.rready is held low, stay in DATA and hold the selected rready low. The target must hold its beat.

Decomposition:
- Package axi_xbar_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADDR, DATA} xbar_state_t;
  - localparams CLINT_BASE_DEF and CLINT_MASK_DEF;
  - typedef enum logic {SEL_MEM, SEL_CLINT} xbar_sel_t.
- One combinational sub-module, axi_addr_decode (addr in, sel out), kept separate for reuse by the future write crossbar. Everything else stays in axi_read_xbar.

Test Plan:
- Reset release: hold i_reset low 3 cycles, then release. Required: in.arready = 1 in the first cycle after release; all rvalid/arvalid = 0; o_skip_difftest = 0.
- CLINT read: AR to 0x0200_0004 with the CLINT model at hmtime = 0x5. Required: out_clint.arvalid at T+1 with araddr 0x0200_0004; out_mem.arvalid stays 0; in.rdata = 0x5 with rresp = 0; o_skip_difftest pulses 1 for one cycle after the R handshake.
- Mem read: AR to 0x8000_0000, memory model returns 0xDEAD_BEEF after 4 cycles with arready delayed 2 cycles. Required: ADDR held 2 cycles with stable araddr; in.rdata = 0xDEAD_BEEF; o_skip_difftest stays 0.
- Boundaries: back-to-back ARs to 0x0200_FFFF then 0x0201_0000. Required: first routes to CLINT, second to mem; second AR is accepted only after the first R completes.
- Back-pressure: in.rready held 0 for 5 cycles during a CLINT read. Required: in.rvalid stays 1 with data stable; out_clint.rready stays 0; completion occurs on the cycle in.rready rises.
- Async reset mid-operation: assert i_reset low during DATA, between clock edges. Required: in.rvalid drops immediately, without waiting for a clock edge; state returns to IDLE; the next post-reset AR to mem completes normally.

Source files
------------

// File: rtl/axi_read_xbar_pkg.sv
// Shared types and defaults for the AXI read crossbar and its address decoder.
package axi_xbar_pkg;

    // Crossbar transaction phase.
    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } xbar_state_t;

    // Downstream port selection; mem is the reset/default route.
    typedef enum logic {
        SEL_MEM,
        SEL_CLINT
    } xbar_sel_t;

    localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
    localparam logic [31:0] CLINT_MASK_DEF = 32'hFFFF_0000;

endpackage

// File: rtl/axi_read_xbar_if.sv
// AXI read-channel subset (AR + R) shared by the LSU, CLINT and memory ports.
interface if_axi_read #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_read_xbar_decode.sv
// Address decoder: routes an address to the CLINT when it falls in the
// masked CLINT window, otherwise to main memory. There is no error route.
module axi_addr_decode
    import axi_xbar_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] CLINT_BASE = CLINT_BASE_DEF,
    parameter logic [ADDR_W-1:0] CLINT_MASK = CLINT_MASK_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output xbar_sel_t         sel
);

    assign sel = ((addr & CLINT_MASK) == CLINT_BASE) ? SEL_CLINT : SEL_MEM;

endmodule

// File: rtl/axi_read_xbar.sv
// 1-to-2 AXI read crossbar between the LSU read master and the CLINT /
// main-memory read slaves. One transaction is in flight at a time; the
// request address is registered, the R beat is passed through combinationally.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for an upstream AR (arready high)
// ADDR  | presenting the captured AR to the selected port until accepted
// DATA  | passing the selected port's R beat upstream until handshaken
module axi_read_xbar
    import axi_xbar_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] CLINT_BASE = CLINT_BASE_DEF,
    parameter logic [ADDR_W-1:0] CLINT_MASK = CLINT_MASK_DEF
) (
    input  logic       i_clock,
    input  logic       i_reset,
    if_axi_read.slave  in,
    if_axi_read.master out_clint,
    if_axi_read.master out_mem,
    output logic       o_skip_difftest
);

    xbar_state_t       state;
    xbar_state_t       state_nxt;
    logic [ADDR_W-1:0] araddr_q;
    xbar_sel_t         sel_q;
    xbar_sel_t         sel_dec;
    logic              ar_fire;
    logic              sel_arready;
    logic              sel_rvalid;
    logic              r_fire;

    axi_addr_decode #(
        .ADDR_W     (ADDR_W),
        .CLINT_BASE (CLINT_BASE),
        .CLINT_MASK (CLINT_MASK)
    ) u_decode (
        .addr (in.araddr),
        .sel  (sel_dec)
    );

    assign ar_fire     = in.arvalid && (state == IDLE);
    assign sel_arready = (sel_q == SEL_CLINT) ? out_clint.arready : out_mem.arready;
    assign sel_rvalid  = (sel_q == SEL_CLINT) ? out_clint.rvalid  : out_mem.rvalid;
    assign r_fire      = (state == DATA) && sel_rvalid && in.rready;

    // State register; async reset abandons any in-flight transaction.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture address and route at upstream AR acceptance.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            araddr_q <= '0;
            sel_q    <= SEL_MEM;
        end else if (ar_fire) begin
            araddr_q <= in.araddr;
            sel_q    <= sel_dec;
        end
    end

    // One-cycle pulse after a CLINT beat completes so difftest skips it.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_skip_difftest <= 1'b0;
        end else begin
            o_skip_difftest <= r_fire && (sel_q == SEL_CLINT);
        end
    end

    // Next-state: IDLE -> ADDR on AR, ADDR -> DATA on downstream AR, DATA -> IDLE on R.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in.arvalid)  state_nxt = ADDR;
            ADDR:    if (sel_arready) state_nxt = DATA;
            DATA:    if (r_fire)      state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Channel steering: AR to the selected port in ADDR, R pass-through in DATA.
    always_comb begin
        in.arready        = (state == IDLE);
        in.rvalid         = 1'b0;
        in.rdata          = '0;
        in.rresp          = '0;
        out_clint.arvalid = 1'b0;
        out_clint.araddr  = araddr_q;
        out_clint.rready  = 1'b0;
        out_mem.arvalid   = 1'b0;
        out_mem.araddr    = araddr_q;
        out_mem.rready    = 1'b0;
        case (state)
            ADDR: begin
                if (sel_q == SEL_CLINT) begin
                    out_clint.arvalid = 1'b1;
                end else begin
                    out_mem.arvalid = 1'b1;
                end
            end
            DATA: begin
                if (sel_q == SEL_CLINT) begin
                    in.rvalid        = out_clint.rvalid;
                    in.rdata         = out_clint.rdata;
                    in.rresp         = out_clint.rresp;
                    out_clint.rready = in.rready;
                end else begin
                    in.rvalid      = out_mem.rvalid;
                    in.rdata       = out_mem.rdata;
                    in.rresp       = out_mem.rresp;
                    out_mem.rready = in.rready;
                end
            end
            default: ;
        endcase
    end

endmodule
